// File: rtl/mem_wb_pipe_reg.sv
// MEM/WB pipeline register with valid/ready handshake and a 2-entry skid buffer.
// The head (main) register drives the WB-facing outputs. The skid register
// catches the one extra entry that can arrive while WB is stalled. in_ready is
// a registered decode of occupancy, so out_ready never reaches in_ready
// combinationally.
//
// Optional build macro: MEM_WB_STALL_CNT_EN
//   Adds a 32-bit saturating stall_cnt output. It counts cycles where
//   out_valid & !out_ready. Only reset clears it; flush leaves it alone.
//
// state    | meaning
// ---------+------------------------------------------------
// ST_EMPTY | no entries held, outputs show stale main data
// ST_ONE   | main holds the head entry
// ST_FULL  | main holds the head entry, skid holds the next one

module mem_wb_pipe_reg #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        WB,
  input  logic [DATA_W-1:0] Read_Data,
  input  logic [RD_W-1:0]   rd,
  input  logic [ADDR_W-1:0] Mem_Address,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              Mem_to_Reg,
  output logic              Reg_Write,
  output logic [DATA_W-1:0] Read_Data_out,
  output logic [RD_W-1:0]   rd_out,
  output logic [ADDR_W-1:0] Mem_Address_out
`ifdef MEM_WB_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [1:0]        wb;
    logic [DATA_W-1:0] data;
    logic [RD_W-1:0]   rd;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  state_e state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   in_ready_q, in_ready_d;
  logic   out_valid_q, out_valid_d;

  entry_t in_entry;
  logic   in_fire;
  logic   out_fire;

  assign in_entry = '{wb: WB, data: Read_Data, rd: rd, addr: Mem_Address};
  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  // Next-state and storage update; a flush forces EMPTY and blocks any load so
  // the entry offered on that cycle is discarded without disturbing main/skid.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_ONE;
            main_d  = in_entry;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_entry;
          end else if (in_fire) begin
            state_d = ST_FULL;
            skid_d  = in_entry;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // Handshake flags are registered decodes of the next occupancy.
  always_comb begin
    in_ready_d  = (state_d != ST_FULL);
    out_valid_d = (state_d != ST_EMPTY);
  end

  // State, storage and handshake flops; reset also zeroes both data registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready        = in_ready_q;
  assign out_valid       = out_valid_q;
  assign Mem_to_Reg      = main_q.wb[0];
  assign Reg_Write       = main_q.wb[1] & out_valid_q;
  assign Read_Data_out   = main_q.data;
  assign rd_out          = main_q.rd;
  assign Mem_Address_out = main_q.addr;

`ifdef MEM_WB_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles where WB holds off a valid head entry.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid_q && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Stall counter flop; intentionally survives flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Directed and randomized checks for mem_wb_pipe_reg (default parameters).
module tb_mem_wb_pipe_reg;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready;
  logic [1:0]  WB;
  logic [63:0] Read_Data, Mem_Address;
  logic [4:0]  rd;
  logic        out_valid, out_ready, Mem_to_Reg, Reg_Write;
  logic [63:0] Read_Data_out, Mem_Address_out;
  logic [4:0]  rd_out;
`ifdef MEM_WB_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  wb;
    logic [63:0] data;
    logic [4:0]  rd;
    logic [63:0] addr;
  } ent_t;
  ent_t mq[$];

  mem_wb_pipe_reg #(.DATA_W(64), .ADDR_W(64), .RD_W(5)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .WB(WB), .Read_Data(Read_Data), .rd(rd), .Mem_Address(Mem_Address),
    .out_valid(out_valid), .out_ready(out_ready),
    .Mem_to_Reg(Mem_to_Reg), .Reg_Write(Reg_Write),
    .Read_Data_out(Read_Data_out), .rd_out(rd_out),
    .Mem_Address_out(Mem_Address_out)
`ifdef MEM_WB_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] r, input logic [1:0] w,
                       input logic [63:0] d, input logic [63:0] a);
    in_valid = v; rd = r; WB = w; Read_Data = d; Mem_Address = a;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 5'd0, 2'b00, 64'h0, 64'h0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset / idle state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_reg_write", Reg_Write, 0);
    chk("rst_mem_to_reg", Mem_to_Reg, 0);
    chk("rst_read_data", Read_Data_out, 0);
    chk("rst_rd", rd_out, 0);
    chk("rst_addr", Mem_Address_out, 0);
`ifdef MEM_WB_STALL_CNT_EN
    chk("rst_stall_cnt", stall_cnt, 0);
`endif

    // Streaming at full throughput
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'(i + 1), 2'b11, 64'hA0 + 64'(i), 64'h1000 + 64'(i));
      tick();
      chk("stream_valid", out_valid, 1);
      chk("stream_rd", rd_out, 64'(i + 1));
      chk("stream_data", Read_Data_out, 64'hA0 + 64'(i));
      chk("stream_addr", Mem_Address_out, 64'h1000 + 64'(i));
      chk("stream_m2r", Mem_to_Reg, 1);
      chk("stream_rw", Reg_Write, 1);
      chk("stream_in_ready", in_ready, 1);
    end
    drive(1'b0, 5'd0, 2'b00, 64'h0, 64'h0);
    tick();
    chk("drain_valid", out_valid, 0);
    chk("drain_rw", Reg_Write, 0);
    chk("drain_stale_rd", rd_out, 4);

    // Backpressure fills main then skid
    out_ready = 1'b0;
    drive(1'b1, 5'd5, 2'b10, 64'hB5, 64'h2005);
    tick();
    chk("stall1_valid", out_valid, 1);
    chk("stall1_rd", rd_out, 5);
    chk("stall1_in_ready", in_ready, 1);
    chk("stall1_m2r", Mem_to_Reg, 0);
    chk("stall1_rw", Reg_Write, 1);
    drive(1'b1, 5'd6, 2'b01, 64'hB6, 64'h2006);
    tick();
    chk("full_in_ready", in_ready, 0);
    chk("full_rd_hold", rd_out, 5);
    chk("full_data_hold", Read_Data_out, 64'hB5);
    drive(1'b1, 5'd9, 2'b11, 64'hB9, 64'h2009);
    tick();
    chk("full2_in_ready", in_ready, 0);
    chk("full2_rd_hold", rd_out, 5);
    drive(1'b0, 5'd0, 2'b00, 64'h0, 64'h0);
    out_ready = 1'b1;
    tick();
    chk("rel1_rd", rd_out, 6);
    chk("rel1_data", Read_Data_out, 64'hB6);
    chk("rel1_addr", Mem_Address_out, 64'h2006);
    chk("rel1_m2r", Mem_to_Reg, 1);
    chk("rel1_rw", Reg_Write, 0);
    chk("rel1_in_ready", in_ready, 1);
    chk("rel1_valid", out_valid, 1);
    tick();
    chk("rel2_valid", out_valid, 0);
    chk("rel2_no_dup_rd", rd_out, 6);

    // Flush while FULL, with a new entry offered on the flush cycle
    out_ready = 1'b0;
    drive(1'b1, 5'd10, 2'b11, 64'hC0, 64'h3000);
    tick();
    drive(1'b1, 5'd11, 2'b11, 64'hC1, 64'h3001);
    tick();
    chk("pre_flush_in_ready", in_ready, 0);
    flush = 1'b1;
    drive(1'b1, 5'd7, 2'b11, 64'hC7, 64'h3007);
    tick();
    flush = 1'b0;
    drive(1'b0, 5'd0, 2'b00, 64'h0, 64'h0);
    chk("flush_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    chk("flush_rw", Reg_Write, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_flush_valid", out_valid, 0);
    end

    // Stall counter: 5 stalled cycles, flush keeps it, reset clears it
    reset = 1'b1; tick(); reset = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 5'd12, 2'b11, 64'hD0, 64'h4000);
    tick();
    drive(1'b0, 5'd0, 2'b00, 64'h0, 64'h0);
    for (int i = 0; i < 5; i++) tick();
    chk("stall_valid", out_valid, 1);
`ifdef MEM_WB_STALL_CNT_EN
    chk("stall_cnt_5", stall_cnt, 5);
`endif
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; out_ready = 1'b0;
    tick();
`ifdef MEM_WB_STALL_CNT_EN
    chk("stall_cnt_flush", stall_cnt, 5);
`endif

    // Reset while FULL
    drive(1'b1, 5'd13, 2'b11, 64'hE0, 64'h5000);
    tick();
    drive(1'b1, 5'd14, 2'b11, 64'hE1, 64'h5001);
    tick();
    chk("pre_rst_in_ready", in_ready, 0);
    reset = 1'b1;
    drive(1'b0, 5'd0, 2'b00, 64'h0, 64'h0);
    tick();
    reset = 1'b0;
    chk("rst2_valid", out_valid, 0);
    chk("rst2_in_ready", in_ready, 1);
    chk("rst2_rd", rd_out, 0);
    chk("rst2_data", Read_Data_out, 0);
    chk("rst2_addr", Mem_Address_out, 0);
`ifdef MEM_WB_STALL_CNT_EN
    chk("rst2_stall_cnt", stall_cnt, 0);
`endif

    // Random traffic against a queue model
    mq.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      ent_t e;
      e.wb   = 2'($urandom_range(0, 3));
      e.rd   = 5'($urandom_range(0, 31));
      e.data = {$urandom, $urandom};
      e.addr = {$urandom, $urandom};
      drive(1'($urandom_range(0, 1)), e.rd, e.wb, e.data, e.addr);
      out_ready = 1'($urandom_range(0, 1));
      #1;
      chk("rnd_valid", out_valid, (mq.size() != 0) ? 1 : 0);
      chk("rnd_in_ready", in_ready, (mq.size() < 2) ? 1 : 0);
      if (mq.size() != 0) begin
        chk("rnd_rd", rd_out, mq[0].rd);
        chk("rnd_data", Read_Data_out, mq[0].data);
        chk("rnd_addr", Mem_Address_out, mq[0].addr);
        chk("rnd_m2r", Mem_to_Reg, mq[0].wb[0]);
        chk("rnd_rw", Reg_Write, mq[0].wb[1]);
      end else begin
        chk("rnd_bubble_rw", Reg_Write, 0);
      end
      if ((mq.size() != 0) && out_ready) void'(mq.pop_front());
      if (in_valid && (mq.size() < 2 || (mq.size() == 2 && 1'b0))) begin
        if (in_ready) mq.push_back(e);
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
